// File: rtl/datastore_pkg.sv
// datastore_pkg: shared defaults, command encoding and the command
// priority encoder for the keystroke byte store.
package datastore_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 28;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_CLEAR,
      CMD_WRITE,
      CMD_APPEND,
      CMD_BACK
   } cmd_e;

   // One command per cycle: clear > write > append > backspace.
   function automatic cmd_e prio_cmd(input logic clear,
                                     input logic wr_en,
                                     input logic append_en,
                                     input logic backspace);
      if (clear)     return CMD_CLEAR;
      if (wr_en)     return CMD_WRITE;
      if (append_en) return CMD_APPEND;
      if (backspace) return CMD_BACK;
      return CMD_NONE;
   endfunction

endpackage

// File: rtl/datastore_if.sv
// datastore_if: command/read bus of the byte store.
//   master: drives wr_data/wr_index/wr_en/append_en/backspace/clear/rd_index,
//           observes rd_data/flat_out/count/full/empty/overflow/idx_err.
//   slave : the store itself (opposite directions).
interface datastore_if
   import datastore_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned IDX_W  = $clog2(DEPTH),
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) ();

   logic [DATA_W-1:0]       wr_data;
   logic [IDX_W-1:0]        wr_index;
   logic                    wr_en;
   logic                    append_en;
   logic                    backspace;
   logic                    clear;
   logic [IDX_W-1:0]        rd_index;
   logic [DATA_W-1:0]       rd_data;
   logic [DATA_W*DEPTH-1:0] flat_out;
   logic [CNT_W-1:0]        count;
   logic                    full;
   logic                    empty;
   logic                    overflow;
   logic                    idx_err;

   modport master (
      output wr_data, wr_index, wr_en, append_en, backspace, clear, rd_index,
      input  rd_data, flat_out, count, full, empty, overflow, idx_err
   );

   modport slave (
      input  wr_data, wr_index, wr_en, append_en, backspace, clear, rd_index,
      output rd_data, flat_out, count, full, empty, overflow, idx_err
   );

endinterface

// File: rtl/datastore_ptr.sv
// datastore_ptr: append pointer / entry count with saturation at 0 and
// DEPTH, plus full/empty and the sticky overflow flag.
//   clk, reset_n : clock, async active-low reset
//   cmd          : decoded command for this cycle
//   count        : valid appended entries (= append pointer)
//   full, empty  : combinational from count
//   overflow     : set by an append while full, cleared by clear/reset
module datastore_ptr
   import datastore_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  cmd_e             cmd,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         case (cmd)
            CMD_CLEAR: begin
               count    <= '0;
               overflow <= 1'b0;
            end
            CMD_APPEND: begin
               if (full) overflow <= 1'b1;
               else      count    <= count + CNT_W'(1);
            end
            CMD_BACK: begin
               if (!empty) count <= count - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/datastore_buf.sv
// datastore_buf: keystroke byte store feeding the cipher as a flat vector.
//   clk, reset_n : clock, async active-low reset
//   bus          : datastore_if slave (commands, read port, status)
// Holds the entry array, the registered read port and the flattening;
// count/flags live in datastore_ptr.
module datastore_buf
   import datastore_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned IDX_W  = $clog2(DEPTH),
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic        clk,
   input  logic        reset_n,
   datastore_if.slave  bus
);

   logic [DATA_W-1:0]       mem [DEPTH];
   logic [DATA_W-1:0]       rd_q;
   logic                    err_q;
   logic [DATA_W*DEPTH-1:0] flat;
   logic [CNT_W-1:0]        count;
   logic                    full;
   logic                    empty;
   logic                    overflow;
   logic [IDX_W-1:0]        app_ptr;
   logic [IDX_W-1:0]        last_ptr;
   logic                    wr_ok;
   logic                    rd_ok;
   cmd_e                    cmd;

   assign cmd      = prio_cmd(bus.clear, bus.wr_en, bus.append_en, bus.backspace);
   assign wr_ok    = (32'(bus.wr_index) < DEPTH);
   assign rd_ok    = (32'(bus.rd_index) < DEPTH);
   // Only used when not full / not empty, so truncation never aliases.
   assign app_ptr  = IDX_W'(count);
   assign last_ptr = IDX_W'(count - CNT_W'(1));

   datastore_ptr #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_ptr (
      .clk      (clk),
      .reset_n  (reset_n),
      .cmd      (cmd),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .overflow (overflow)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem <= '{default: '0};
      end else begin
         case (cmd)
            CMD_CLEAR:  mem <= '{default: '0};
            CMD_WRITE:  if (wr_ok)  mem[bus.wr_index] <= bus.wr_data;
            CMD_APPEND: if (!full)  mem[app_ptr]      <= bus.wr_data;
            CMD_BACK:   if (!empty) mem[last_ptr]     <= '0;
            default: ;
         endcase
      end
   end

   // Read samples pre-edge contents, so a same-cycle write reads old data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         rd_q  <= rd_ok ? mem[bus.rd_index] : '0;
         err_q <= ((cmd == CMD_WRITE) && !wr_ok) || !rd_ok;
      end
   end

   always_comb begin
      flat = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         flat[DATA_W*i +: DATA_W] = mem[i];
      end
   end

   assign bus.rd_data  = rd_q;
   assign bus.idx_err  = err_q;
   assign bus.flat_out = flat;
   assign bus.count    = count;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.overflow = overflow;

endmodule

// File: tb/tb_datastore_buf.sv
// tb_datastore_buf: directed scoreboard bench for datastore_buf, default
// 8x28 instance plus a 16x8 instance for the parameter rerun.
module tb_datastore_buf;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   datastore_if #(.DATA_W(8),  .DEPTH(28)) ia ();
   datastore_if #(.DATA_W(16), .DEPTH(8))  ib ();

   datastore_buf #(.DATA_W(8), .DEPTH(28)) dut_a (
      .clk (clk), .reset_n (reset_n), .bus (ia)
   );
   datastore_buf #(.DATA_W(16), .DEPTH(8)) dut_b (
      .clk (clk), .reset_n (reset_n), .bus (ib)
   );

   int total = 0;
   int bad   = 0;

   // reference model of the 8x28 store
   logic [7:0] m [28];
   int         mcount = 0;
   logic       movf   = 1'b0;
   logic [7:0] rq [$];
   logic       eq [$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [223:0] model_flat();
      logic [223:0] f;
      f = '0;
      for (int i = 0; i < 28; i++) f[8*i +: 8] = m[i];
      return f;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 28; i++) m[i] = 8'h00;
      mcount = 0;
      movf   = 1'b0;
   endtask

   // Drive one cycle on the 8x28 instance; expectations go into the
   // scoreboard before the edge and are checked after it.
   task automatic step(input logic c, input logic w, input logic a, input logic b,
                       input logic [7:0] d, input logic [4:0] wi, input logic [4:0] ri);
      ia.clear = c; ia.wr_en = w; ia.append_en = a; ia.backspace = b;
      ia.wr_data = d; ia.wr_index = wi; ia.rd_index = ri;
      rq.push_back((int'(ri) < 28) ? m[ri] : 8'h00);
      eq.push_back((w && !c && int'(wi) >= 28) || int'(ri) >= 28);
      if (c) model_clear();
      else if (w) begin
         if (int'(wi) < 28) m[wi] = d;
      end else if (a) begin
         if (mcount == 28) movf = 1'b1;
         else begin m[mcount] = d; mcount++; end
      end else if (b) begin
         if (mcount > 0) begin mcount--; m[mcount] = 8'h00; end
      end
      @(posedge clk); #1;
      ia.clear = 0; ia.wr_en = 0; ia.append_en = 0; ia.backspace = 0;
      chk("rd_data",  ia.rd_data,  rq.pop_front());
      chk("idx_err",  ia.idx_err,  eq.pop_front());
      chk("count",    ia.count,    mcount);
      chk("overflow", ia.overflow, movf);
      chk("full",     ia.full,     mcount == 28);
      chk("empty",    ia.empty,    mcount == 0);
      chk("flat_out", ia.flat_out, model_flat());
   endtask

   task automatic idle(input logic [4:0] ri);
      step(0, 0, 0, 0, 8'h00, 5'd0, ri);
   endtask

   logic [127:0] bexp;

   initial begin
      model_clear();
      ia.clear = 0; ia.wr_en = 0; ia.append_en = 0; ia.backspace = 0;
      ia.wr_data = '0; ia.wr_index = '0; ia.rd_index = '0;
      ib.clear = 0; ib.wr_en = 0; ib.append_en = 0; ib.backspace = 0;
      ib.wr_data = '0; ib.wr_index = '0; ib.rd_index = '0;

      // reset values
      #12;
      chk("rst_count",    ia.count,    0);
      chk("rst_empty",    ia.empty,    1);
      chk("rst_full",     ia.full,     0);
      chk("rst_overflow", ia.overflow, 0);
      chk("rst_rd_data",  ia.rd_data,  0);
      chk("rst_idx_err",  ia.idx_err,  0);
      chk("rst_flat",     ia.flat_out, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // fill 0x41..0x5C, then one overflowing append
      for (int i = 0; i < 28; i++) step(0, 0, 1, 0, 8'(8'h41 + i), 5'd0, 5'd0);
      chk("fill_count", ia.count, 28);
      chk("fill_full",  ia.full,  1);
      chk("fill_lo",    ia.flat_out[7:0],     8'h41);
      chk("fill_hi",    ia.flat_out[223:216], 8'h5C);
      step(0, 0, 1, 0, 8'hFF, 5'd0, 5'd27);
      chk("ovf_flag",  ia.overflow, 1);
      chk("ovf_count", ia.count, 28);
      chk("ovf_hi",    ia.flat_out[223:216], 8'h5C);
      idle(5'd27);
      chk("rd_last", ia.rd_data, 8'h5C);

      // append x3 then backspace x4 (one extra on empty)
      step(1, 0, 0, 0, 8'h00, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'hAA, 5'd0, 5'd0);
      chk("aa_count", ia.count, 3);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h00, 5'd0, 5'd0);
      chk("bs_count", ia.count, 0);
      chk("bs_empty", ia.empty, 1);
      chk("bs_ent",   ia.flat_out[23:0], 24'h0);

      // indexed write while count=2, then out-of-range write
      step(0, 0, 1, 0, 8'h01, 5'd0, 5'd0);
      step(0, 0, 1, 0, 8'h02, 5'd0, 5'd0);
      step(0, 1, 0, 0, 8'h55, 5'd7, 5'd0);
      chk("w7_ent",   ia.flat_out[63:56], 8'h55);
      chk("w7_count", ia.count, 2);
      step(0, 1, 0, 0, 8'h99, 5'd30, 5'd0);
      chk("w30_err", ia.idx_err, 1);
      idle(5'd0);
      chk("w30_err_drop", ia.idx_err, 0);

      // overflow again, then clear+append+write together
      for (int i = 0; i < 27; i++) step(0, 0, 1, 0, 8'(i), 5'd0, 5'd0);
      chk("ovf2", ia.overflow, 1);
      step(1, 1, 1, 0, 8'h33, 5'd4, 5'd0);
      chk("clr_count", ia.count, 0);
      chk("clr_ovf",   ia.overflow, 0);
      chk("clr_flat",  ia.flat_out, 0);

      // write beats append
      step(0, 1, 1, 0, 8'h11, 5'd1, 5'd0);
      chk("wa_ent1",  ia.flat_out[15:8], 8'h11);
      chk("wa_ent0",  ia.flat_out[7:0],  8'h00);
      chk("wa_count", ia.count, 0);

      // read-old on same-cycle write
      step(0, 1, 0, 0, 8'h10, 5'd3, 5'd0);
      step(0, 1, 0, 0, 8'h77, 5'd3, 5'd3);
      chk("rdold", ia.rd_data, 8'h10);
      idle(5'd3);
      chk("rdnew", ia.rd_data, 8'h77);

      // out-of-range read
      idle(5'd29);
      chk("rd29_data", ia.rd_data, 0);
      chk("rd29_err",  ia.idx_err, 1);

      // async reset between edges
      step(1, 0, 0, 0, 8'h00, 5'd0, 5'd0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'(8'hC0 + i), 5'd0, 5'd2);
      chk("pre_rst_rd", ia.rd_data, 8'hC2);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_count", ia.count,    0);
      chk("arst_flat",  ia.flat_out, 0);
      chk("arst_rd",    ia.rd_data,  0);
      chk("arst_empty", ia.empty,    1);
      model_clear();
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      idle(5'd0);

      // 16x8 instance: fill, ordering, full, overflow
      bexp = '0;
      for (int i = 0; i < 8; i++) begin
         ib.append_en = 1'b1;
         ib.wr_data   = 16'(16'h1000 + 16'h0101 * i);
         bexp[16*i +: 16] = 16'(16'h1000 + 16'h0101 * i);
         @(posedge clk); #1;
         ib.append_en = 1'b0;
         chk("b_count", ib.count, i + 1);
      end
      chk("b_full", ib.full, 1);
      chk("b_flat", ib.flat_out, bexp);
      ib.append_en = 1'b1; ib.wr_data = 16'hFFFF; ib.rd_index = 3'd5;
      @(posedge clk); #1;
      ib.append_en = 1'b0;
      chk("b_ovf",   ib.overflow, 1);
      chk("b_hold",  ib.flat_out, bexp);
      chk("b_rd5",   ib.rd_data,  16'h1505);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
